// File: rtl/piano_pkg.sv
// Shared definitions for the piano mode controller slice.
//   - state_e      : arbiter FSM states
//   - NOTE_REST    : note code that silences the buzzer
//   - default bus widths and engine index constants
//   - clog2_min1() : index width that never collapses to zero bits
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUTE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int NOTE_REST   = 0;

  localparam int DEF_NUM_MODES = 4;
  localparam int DEF_NOTE_W    = 4;
  localparam int DEF_LED_W     = 7;
  localparam int DEF_NUM_W     = 4;
  localparam int DEF_OCT_W     = 2;
  localparam int DEF_SCORE_W   = 4;
  localparam int DEF_PLAYERS   = 2;

  localparam int MODE_AUTO  = 0;
  localparam int MODE_LEARN = 1;
  localparam int MODE_COMP  = 3;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mode_select_arbiter_onehot_to_index.sv
// Combinational one-hot decoder.
//   onehot_i : candidate one-hot vector
//   idx_o    : index of the set bit (OR of indices when not one-hot)
//   valid_o  : exactly one bit of onehot_i is set
module onehot_to_index
  import piano_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (onehot_i[i]) idx_o = idx_o | IDX_W'(i);
  end

  // Non-zero and clearing the lowest set bit leaves nothing.
  assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 1'b1)) == '0);

endmodule

// File: rtl/mode_select_arbiter.sv
// Mode select arbiter: multiplexes NUM_MODES player engines onto the single
// note/LED/num/octave output path, mutes for MUTE_CYCLES after every mode
// change, owns the play/pause toggle and routes competition scores.
//   clk, reset          : clock, synchronous active-low reset
//   mode                : one-hot mode select
//   start               : play/pause request level
//   user_sel            : player whose total is shown on score_user
//   note/led/num/octave_in : flattened per-mode buses, mode i in slice i
//   score_in, player_score_in : scores from the SCORE_MODE engine
//   note/led/num/octave_out   : registered selected (or idle) values
//   score_out, score_user     : held scores
//   play_state, active_idx, mode_valid : status
module mode_select_arbiter
  import piano_pkg::*;
#(
  parameter int NUM_MODES   = DEF_NUM_MODES,
  parameter int NOTE_W      = DEF_NOTE_W,
  parameter int LED_W       = DEF_LED_W,
  parameter int NUM_W       = DEF_NUM_W,
  parameter int OCT_W       = DEF_OCT_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int PLAYERS     = DEF_PLAYERS,
  parameter int SCORE_MODE  = MODE_COMP,
  parameter int MUTE_CYCLES = 4,
  parameter int DEFAULT_OCT = 1,
  localparam int IDX_W = clog2_min1(NUM_MODES),
  localparam int USR_W = clog2_min1(PLAYERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MODES-1:0]         mode,
  input  logic                         start,
  input  logic [USR_W-1:0]             user_sel,
  input  logic [NUM_MODES*NOTE_W-1:0]  note_in,
  input  logic [NUM_MODES*LED_W-1:0]   led_in,
  input  logic [NUM_MODES*NUM_W-1:0]   num_in,
  input  logic [NUM_MODES*OCT_W-1:0]   octave_in,
  input  logic [SCORE_W-1:0]           score_in,
  input  logic [PLAYERS*SCORE_W-1:0]   player_score_in,
  output logic [NOTE_W-1:0]            note_out,
  output logic [LED_W-1:0]             led_out,
  output logic [NUM_W-1:0]             num_out,
  output logic [OCT_W-1:0]             octave_out,
  output logic [SCORE_W-1:0]           score_out,
  output logic [SCORE_W-1:0]           score_user,
  output logic                         play_state,
  output logic [IDX_W-1:0]             active_idx,
  output logic                         mode_valid
);

  localparam int CNT_W = clog2_min1(MUTE_CYCLES);

  // Per-mode views of the flattened buses.
  logic [NUM_MODES-1:0][NOTE_W-1:0] note_arr;
  logic [NUM_MODES-1:0][LED_W-1:0]  led_arr;
  logic [NUM_MODES-1:0][NUM_W-1:0]  num_arr;
  logic [NUM_MODES-1:0][OCT_W-1:0]  oct_arr;
  logic [PLAYERS-1:0][SCORE_W-1:0]  ps_arr;

  assign note_arr = note_in;
  assign led_arr  = led_in;
  assign num_arr  = num_in;
  assign oct_arr  = octave_in;
  assign ps_arr   = player_score_in;

  state_e                state_q, state_d;
  logic [NUM_MODES-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  mvalid_q, mvalid_d;
  logic                  start_q;
  logic                  play_q, play_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [NUM_W-1:0]      num_q, num_d;
  logic [OCT_W-1:0]      oct_q, oct_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W-1:0]    user_q, user_d;

  logic [IDX_W-1:0]      oh_idx;
  logic                  oh_valid;
  logic                  mode_chg, start_rise, run_load, score_hit;
  logic [USR_W-1:0]      sel_eff;

  onehot_to_index #(.N(NUM_MODES), .IDX_W(IDX_W)) u_oh (
    .onehot_i (mode),
    .idx_o    (oh_idx),
    .valid_o  (oh_valid)
  );

  assign mode_chg   = (mode != mode_q);
  assign start_rise = start & ~start_q;
  // Engine data passes only in a settled RUN; a change at this edge already
  // forces the idle values so the mute starts immediately.
  assign run_load   = (state_q == ST_RUN) && !mode_chg;
  assign score_hit  = (state_q == ST_RUN) && (idx_q == IDX_W'(SCORE_MODE));
  assign sel_eff    = (int'(user_sel) < PLAYERS) ? user_sel : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      mvalid_q <= 1'b0;
      start_q  <= 1'b0;
      play_q   <= 1'b0;
      note_q   <= NOTE_W'(NOTE_REST);
      led_q    <= '0;
      num_q    <= '0;
      oct_q    <= OCT_W'(DEFAULT_OCT);
      score_q  <= '0;
      user_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mvalid_q <= mvalid_d;
      start_q  <= start;
      play_q   <= play_d;
      note_q   <= note_d;
      led_q    <= led_d;
      num_q    <= num_d;
      oct_q    <= oct_d;
      score_q  <= score_d;
      user_q   <= user_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mvalid_d = mvalid_q;
    if (mode_chg) begin
      mode_d = mode;
      if (oh_valid) begin
        state_d  = ST_MUTE;
        cnt_d    = CNT_W'(MUTE_CYCLES - 1);
        idx_d    = oh_idx;
        mvalid_d = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        mvalid_d = 1'b0;
      end
    end else if (state_q == ST_MUTE) begin
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // Output-register next values
  always_comb begin
    note_d  = NOTE_W'(NOTE_REST);
    led_d   = '0;
    num_d   = '0;
    oct_d   = OCT_W'(DEFAULT_OCT);
    play_d  = 1'b0;
    score_d = score_q;
    user_d  = user_q;
    if (run_load) begin
      note_d = note_arr[idx_q];
      led_d  = led_arr[idx_q];
      num_d  = num_arr[idx_q];
      oct_d  = oct_arr[idx_q];
      // Rises outside a settled RUN fall into the zero default: never queued.
      play_d = play_q ^ start_rise;
    end
    if (score_hit) begin
      score_d = score_in;
      user_d  = ps_arr[sel_eff];
    end
  end

  assign note_out   = note_q;
  assign led_out    = led_q;
  assign num_out    = num_q;
  assign octave_out = oct_q;
  assign score_out  = score_q;
  assign score_user = user_q;
  assign play_state = play_q;
  assign active_idx = idx_q;
  assign mode_valid = mvalid_q;

endmodule

// File: tb/tb_mode_select_arbiter.sv
module tb_mode_select_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mode;
  logic        start;
  logic [0:0]  user_sel;
  logic [15:0] note_in;
  logic [27:0] led_in;
  logic [15:0] num_in;
  logic [7:0]  octave_in;
  logic [3:0]  score_in;
  logic [7:0]  player_score_in;
  logic [3:0]  note_out;
  logic [6:0]  led_out;
  logic [3:0]  num_out;
  logic [1:0]  octave_out;
  logic [3:0]  score_out, score_user;
  logic        play_state;
  logic [1:0]  active_idx;
  logic        mode_valid;

  int checks = 0;
  int errors = 0;

  // Per-mode engine data, fixed for the whole run.
  int m_note[4] = '{5, 6, 9, 12};
  int m_led[4]  = '{'h11, 'h22, 'h44, 'h08};
  int m_num[4]  = '{3, 4, 5, 6};
  int m_oct[4]  = '{2, 3, 0, 2};

  mode_select_arbiter dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .user_sel(user_sel),
    .note_in(note_in), .led_in(led_in), .num_in(num_in), .octave_in(octave_in),
    .score_in(score_in), .player_score_in(player_score_in),
    .note_out(note_out), .led_out(led_out), .num_out(num_out),
    .octave_out(octave_out), .score_out(score_out), .score_user(score_user),
    .play_state(play_state), .active_idx(active_idx), .mode_valid(mode_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mode;
    logic       start;
    logic       usel;
    logic [3:0] sc, pa, pb;
    int         src;   // -1: idle values expected, else engine index
    logic       play;
    logic [1:0] idx;
    logic       vld;
    logic [3:0] esc, eusr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [3:0] m, input logic s, input logic u,
                     input logic [3:0] sc, input logic [3:0] pa, input logic [3:0] pb,
                     input int src, input logic pl, input logic [1:0] ix,
                     input logic v, input logic [3:0] esc, input logic [3:0] eu);
    vec_t t;
    t.mode = m; t.start = s; t.usel = u; t.sc = sc; t.pa = pa; t.pb = pb;
    t.src = src; t.play = pl; t.idx = ix; t.vld = v; t.esc = esc; t.eusr = eu;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_path(input int row, input int src);
    chk("note", row, 32'(note_out),   (src < 0) ? 32'd0 : 32'(m_note[src]));
    chk("led",  row, 32'(led_out),    (src < 0) ? 32'd0 : 32'(m_led[src]));
    chk("num",  row, 32'(num_out),    (src < 0) ? 32'd0 : 32'(m_num[src]));
    chk("oct",  row, 32'(octave_out), (src < 0) ? 32'd1 : 32'(m_oct[src]));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      note_in[i*4 +: 4]   = 4'(m_note[i]);
      led_in[i*7 +: 7]    = 7'(m_led[i]);
      num_in[i*4 +: 4]    = 4'(m_num[i]);
      octave_in[i*2 +: 2] = 2'(m_oct[i]);
    end
    reset = 1'b0; mode = 4'b0; start = 1'b0; user_sel = 1'b0;
    score_in = 4'd0; player_score_in = 8'd0;

    //   mode    st u  sc pa pb  src pl idx v  esc eu
    add(4'b0001, 0, 0, 0, 0, 0,  -1, 0, 0, 1, 0, 0); // change: mute
    add(4'b0001, 0, 0, 0, 0, 0,  -1, 0, 0, 1, 0, 0);
    add(4'b0001, 0, 0, 0, 0, 0,  -1, 0, 0, 1, 0, 0);
    add(4'b0001, 0, 0, 0, 0, 0,  -1, 0, 0, 1, 0, 0);
    add(4'b0001, 0, 0, 0, 0, 0,  -1, 0, 0, 1, 0, 0); // enters RUN
    add(4'b0001, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0); // first data
    add(4'b0001, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0); // rise toggles
    add(4'b0001, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0); // held level
    add(4'b0001, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(4'b0001, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(4'b0001, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0); // second pulse
    add(4'b0001, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(4'b0001, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(4'b0001, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(4'b0010, 0, 0, 0, 0, 0,  -1, 0, 1, 1, 0, 0); // change kills play
    add(4'b0010, 0, 0, 0, 0, 0,  -1, 0, 1, 1, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 0,  -1, 0, 2, 1, 0, 0); // mute restart
    add(4'b0100, 1, 0, 0, 0, 0,  -1, 0, 2, 1, 0, 0); // rise in MUTE dropped
    add(4'b0100, 0, 0, 0, 0, 0,  -1, 0, 2, 1, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 0,  -1, 0, 2, 1, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 0,  -1, 0, 2, 1, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 0,   2, 0, 2, 1, 0, 0); // 5 edges after change
    add(4'b0011, 0, 0, 0, 0, 0,  -1, 0, 2, 0, 0, 0); // multi-hot: idx holds
    add(4'b0011, 1, 0, 0, 0, 0,  -1, 0, 2, 0, 0, 0);
    add(4'b0011, 0, 0, 0, 0, 0,  -1, 0, 2, 0, 0, 0);
    add(4'b0011, 1, 0, 0, 0, 0,  -1, 0, 2, 0, 0, 0);
    add(4'b0011, 0, 0, 0, 0, 0,  -1, 0, 2, 0, 0, 0);
    add(4'b1000, 0, 1, 7, 3, 9,  -1, 0, 3, 1, 0, 0); // competition mode
    add(4'b1000, 0, 1, 7, 3, 9,  -1, 0, 3, 1, 0, 0);
    add(4'b1000, 0, 1, 7, 3, 9,  -1, 0, 3, 1, 0, 0);
    add(4'b1000, 0, 1, 7, 3, 9,  -1, 0, 3, 1, 0, 0);
    add(4'b1000, 0, 1, 7, 3, 9,  -1, 0, 3, 1, 0, 0);
    add(4'b1000, 0, 1, 7, 3, 9,   3, 0, 3, 1, 7, 9); // scores routed
    add(4'b1000, 0, 0, 7, 3, 9,   3, 0, 3, 1, 7, 3); // player A
    add(4'b0001, 0, 0, 7, 3, 9,  -1, 0, 0, 1, 7, 3); // leaves score mode
    add(4'b0001, 0, 1, 15, 1, 2, -1, 0, 0, 1, 7, 3); // scores hold
    add(4'b0001, 0, 1, 15, 1, 2, -1, 0, 0, 1, 7, 3);
    add(4'b0000, 0, 1, 15, 1, 2, -1, 0, 0, 0, 7, 3); // no mode

    // Reset state
    step(); step();
    chk_path(-1, -1);
    chk("play",  -1, 32'(play_state), 32'd0);
    chk("idx",   -1, 32'(active_idx), 32'd0);
    chk("valid", -1, 32'(mode_valid), 32'd0);
    chk("score", -1, 32'(score_out),  32'd0);
    chk("user",  -1, 32'(score_user), 32'd0);

    reset = 1'b1;
    foreach (tv[r]) begin
      mode = tv[r].mode; start = tv[r].start; user_sel = tv[r].usel;
      score_in = tv[r].sc; player_score_in = {tv[r].pb, tv[r].pa};
      step();
      chk_path(r, tv[r].src);
      chk("play",  r, 32'(play_state), 32'(tv[r].play));
      chk("idx",   r, 32'(active_idx), 32'(tv[r].idx));
      chk("valid", r, 32'(mode_valid), 32'(tv[r].vld));
      chk("score", r, 32'(score_out),  32'(tv[r].esc));
      chk("user",  r, 32'(score_user), 32'(tv[r].eusr));
    end

    // Reset coinciding with a mode change and a start rise: reset wins and
    // clears the held scores.
    mode = 4'b0100; start = 1'b1; reset = 1'b0;
    step();
    chk_path(100, -1);
    chk("rst_play",  100, 32'(play_state), 32'd0);
    chk("rst_valid", 100, 32'(mode_valid), 32'd0);
    chk("rst_idx",   100, 32'(active_idx), 32'd0);
    chk("rst_score", 100, 32'(score_out),  32'd0);
    chk("rst_user",  100, 32'(score_user), 32'd0);

    // After release the held mode is seen as a fresh change.
    reset = 1'b1; start = 1'b0;
    step();
    chk("post_valid", 101, 32'(mode_valid), 32'd1);
    chk("post_idx",   101, 32'(active_idx), 32'd2);
    chk_path(101, -1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_path(102 + k, -1);
    end
    step();
    chk_path(106, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
